// File: rtl/bsg_manycore_reg_id_pending_tracker.sv
// rtl/bsg_manycore_reg_id_pending_tracker.sv - per-reg_id in-flight remote request scoreboard
module bsg_manycore_reg_id_pending_tracker #(
  parameter int reg_id_width_p = 5,
  parameter int count_width_p  = 2,
  parameter int max_out_p      = 16,
  localparam int lg_max_out_lp = $clog2(max_out_p+1),
  localparam int num_entries_lp = 1 << reg_id_width_p
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  input  logic [reg_id_width_p-1:0] reg_id_i,
  output logic                      ready_o,
  input  logic                      resp_v_i,
  input  logic [reg_id_width_p-1:0] resp_reg_id_i,
  output logic [num_entries_lp-1:0] pending_o,
  output logic [lg_max_out_lp-1:0]  outstanding_o,
  output logic                      idle_o,
  output logic                      err_o
);

  localparam logic [count_width_p-1:0] count_max_lp = '1;
  localparam logic [lg_max_out_lp-1:0] max_out_lp = lg_max_out_lp'(max_out_p);

  logic [num_entries_lp-1:0][count_width_p-1:0] count_r;
  logic [lg_max_out_lp-1:0] total_r;
  logic err_r;

  logic acc, ret, resp_hit_zero;
  logic [num_entries_lp-1:0] inc_dec, ret_dec;

  // Ready looks only at pre-update state, so a same-cycle retire never unblocks issue.
  assign ready_o = (count_r[reg_id_i] != count_max_lp) && (total_r != max_out_lp);
  assign acc = v_i & ready_o;
  assign resp_hit_zero = (count_r[resp_reg_id_i] == '0);
  assign ret = resp_v_i & ~resp_hit_zero;

  assign inc_dec = acc ? (num_entries_lp'(1) << reg_id_i) : '0;
  assign ret_dec = ret ? (num_entries_lp'(1) << resp_reg_id_i) : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else begin
      for (int r = 0; r < num_entries_lp; r++) begin
        if (inc_dec[r] & ~ret_dec[r])
          count_r[r] <= count_r[r] + count_width_p'(1);
        else if (ret_dec[r] & ~inc_dec[r])
          count_r[r] <= count_r[r] - count_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      total_r <= '0;
    end else begin
      case ({acc, ret})
        2'b10:   total_r <= total_r + lg_max_out_lp'(1);
        2'b01:   total_r <= total_r - lg_max_out_lp'(1);
        default: total_r <= total_r;
      endcase
    end
  end

  // A response with nothing to retire means tracking has been lost; latch it until reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      err_r <= 1'b0;
    else if (resp_v_i & resp_hit_zero)
      err_r <= 1'b1;
  end

  always_comb begin
    pending_o = '0;
    for (int r = 0; r < num_entries_lp; r++)
      pending_o[r] = |count_r[r];
  end

  assign outstanding_o = total_r;
  assign idle_o = (total_r == '0);
  assign err_o = err_r;

endmodule

// File: tb/tb_bsg_manycore_reg_id_pending_tracker.sv
// tb/tb_bsg_manycore_reg_id_pending_tracker.sv - self-checking bench for the reg_id pending tracker
module tb_bsg_manycore_reg_id_pending_tracker;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  logic v_i = 1'b0;
  logic [4:0] reg_id_i = '0;
  logic ready_o;
  logic resp_v_i = 1'b0;
  logic [4:0] resp_reg_id_i = '0;
  logic [31:0] pending_o;
  logic [4:0] outstanding_o;
  logic idle_o;
  logic err_o;

  int total = 0;
  int bad = 0;

  int m_cnt [32];
  int m_total;
  bit m_err;

  always #5 clk_i = ~clk_i;

  bsg_manycore_reg_id_pending_tracker dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .v_i(v_i),
    .reg_id_i(reg_id_i),
    .ready_o(ready_o),
    .resp_v_i(resp_v_i),
    .resp_reg_id_i(resp_reg_id_i),
    .pending_o(pending_o),
    .outstanding_o(outstanding_o),
    .idle_o(idle_o),
    .err_o(err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int id);
    return (m_cnt[id] < 3) && (m_total < 16);
  endfunction

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_total = 0;
      m_err = 0;
    end else begin
      bit a, r;
      a = v_i && m_ready(int'(reg_id_i));
      r = resp_v_i && (m_cnt[resp_reg_id_i] > 0);
      if (resp_v_i && !r) m_err = 1;
      if (a) m_cnt[reg_id_i]++;
      if (r) m_cnt[resp_reg_id_i]--;
      m_total += int'(a) - int'(r);
    end
  end

  always @(negedge clk_i) begin
    logic [31:0] exp_pend;
    exp_pend = '0;
    for (int i = 0; i < 32; i++) exp_pend[i] = (m_cnt[i] != 0);
    check("cyc_ready", 32'(ready_o), 32'(m_ready(int'(reg_id_i))));
    check("cyc_pending", pending_o, exp_pend);
    check("cyc_outstanding", 32'(outstanding_o), 32'(m_total));
    check("cyc_idle", 32'(idle_o), 32'(m_total == 0));
    check("cyc_err", 32'(err_o), 32'(m_err));
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    v_i = 0; resp_v_i = 0;
    reset_n_i = 0;
    step(); step();
    reset_n_i = 1;
  endtask

  task automatic issue(input int id);
    v_i = 1; reg_id_i = 5'(id);
    step();
    v_i = 0;
  endtask

  task automatic respond(input int id);
    resp_v_i = 1; resp_reg_id_i = 5'(id);
    step();
    resp_v_i = 0;
  endtask

  initial begin
    // 1: reset defaults, checked while still in reset
    #2;
    check("rst_pending", pending_o, 32'h0);
    check("rst_outstanding", 32'(outstanding_o), 0);
    check("rst_idle", 32'(idle_o), 1);
    check("rst_ready", 32'(ready_o), 1);
    check("rst_err", 32'(err_o), 0);
    do_reset();

    // 2: entry saturation on reg_id 3
    for (int i = 0; i < 3; i++) issue(3);
    v_i = 1; reg_id_i = 5'd3;
    #1;
    check("sat_ready", 32'(ready_o), 0);
    check("sat_pend3", 32'(pending_o[3]), 1);
    check("sat_outstanding", 32'(outstanding_o), 3);
    resp_v_i = 1; resp_reg_id_i = 5'd3;
    step();
    resp_v_i = 0;
    check("sat_ready_after", 32'(ready_o), 1);
    check("sat_outstanding_after", 32'(outstanding_o), 2);
    v_i = 0;
    step();
    do_reset();

    // 3: global budget
    for (int id = 0; id < 8; id++) begin
      issue(id);
      issue(id);
    end
    check("bud_outstanding", 32'(outstanding_o), 16);
    for (int id = 0; id < 32; id++) begin
      reg_id_i = 5'(id);
      #1;
      check("bud_ready", 32'(ready_o), 0);
    end
    reg_id_i = 5'd20;
    v_i = 1;
    #1;
    check("bud_ready20", 32'(ready_o), 0);
    v_i = 0;
    respond(0);
    check("bud_ready_after", 32'(ready_o), 1);
    check("bud_outstanding_after", 32'(outstanding_o), 15);
    do_reset();

    // 4: simultaneous issue and response
    issue(5);
    v_i = 1; reg_id_i = 5'd5; resp_v_i = 1; resp_reg_id_i = 5'd5;
    step();
    v_i = 0; resp_v_i = 0;
    check("sim_pend5", 32'(pending_o[5]), 1);
    check("sim_outstanding", 32'(outstanding_o), 1);
    v_i = 1; reg_id_i = 5'd6; resp_v_i = 1; resp_reg_id_i = 5'd5;
    step();
    v_i = 0; resp_v_i = 0;
    check("sim2_pend5", 32'(pending_o[5]), 0);
    check("sim2_pend6", 32'(pending_o[6]), 1);
    check("sim2_outstanding", 32'(outstanding_o), 1);

    // 5: spurious response
    respond(9);
    step(); step();
    check("spur_err", 32'(err_o), 1);
    check("spur_pending", pending_o, 32'h0000_0040);
    check("spur_outstanding", 32'(outstanding_o), 1);
    check("spur_idle", 32'(idle_o), 0);
    do_reset();

    // 6: async reset mid-traffic
    for (int id = 0; id < 4; id++) issue(id);
    check("ar_outstanding_pre", 32'(outstanding_o), 4);
    reset_n_i = 0;
    #2;
    check("ar_outstanding", 32'(outstanding_o), 0);
    check("ar_pending", pending_o, 32'h0);
    check("ar_idle", 32'(idle_o), 1);
    check("ar_ready", 32'(ready_o), 1);
    #1;
    reset_n_i = 1;
    step();
    respond(0);
    check("ar_err", 32'(err_o), 1);
    check("ar_outstanding_post", 32'(outstanding_o), 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
